fd_queue_stage: RTL and testbench

- Parametrised fetch/decode stage. Replaces the single-entry FD latch pair (PC and instruction registers) with a DEPTH-entry instruction queue.
- Accepts one PC/instruction pair per cycle from fetch using a valid/ready handshake. Presents the oldest entry to decode with pre-decoded register fields and class flags.
- Supports a pipeline flush on branch/jump redirect.
- Sits between the ROM fetch logic and the decode/register-read stage.

---
 rtl/fd_pkg.sv | 14 +
 rtl/fd_queue_stage_if.sv | 13 +
 rtl/fd_decode.sv | 29 ++
 rtl/fd_queue_stage.sv | 83 ++++++++
 tb/tb_fd_queue_stage.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fd_pkg.sv
// Shared fetch/decode constants: opcode encodings and fixed instruction field positions.
package fd_pkg;
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_BNE   = 5'b00010;
  localparam logic [4:0] OP_JR    = 5'b00100;
  localparam logic [4:0] OP_ADDI  = 5'b00101;
  localparam logic [4:0] OP_BLT   = 5'b00110;
  localparam logic [4:0] OP_BEX   = 5'b10110;

  localparam int RD_LSB = 22;
  localparam int RS_LSB = 17;
  localparam int RT_LSB = 12;
  localparam int OP_LSB = 27;
endpackage

// File: rtl/fd_queue_stage_if.sv
// Fetch-side valid/ready handshake carrying one PC/instruction pair per cycle.
interface fd_queue_stage_if #(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32
);
  logic               fetch_valid;
  logic               fetch_ready;
  logic [PC_W-1:0]    pc_in;
  logic [INSTR_W-1:0] instr_in;

  modport master (output fetch_valid, pc_in, instr_in, input fetch_ready);
  modport slave  (input fetch_valid, pc_in, instr_in, output fetch_ready);
endinterface

// File: rtl/fd_decode.sv
// Combinational pre-decode of register fields and class flags; flags gated by valid.
module fd_decode
  import fd_pkg::*;
(
  input  logic [OP_LSB+4:RT_LSB] instr_hi,
  input  logic                   valid,
  output logic [4:0]             rd,
  output logic [4:0]             rs,
  output logic [4:0]             rt,
  output logic                   rtype,
  output logic                   addi,
  output logic                   bex,
  output logic                   jr,
  output logic                   branch
);
  logic [4:0] op;

  assign op = instr_hi[OP_LSB+:5];
  assign rd = instr_hi[RD_LSB+:5];
  assign rs = instr_hi[RS_LSB+:5];
  assign rt = instr_hi[RT_LSB+:5];

  // An all-zero word decodes as rtype, so the valid gate is what keeps an empty head silent.
  assign rtype  = valid & (op == OP_RTYPE);
  assign addi   = valid & (op == OP_ADDI);
  assign bex    = valid & (op == OP_BEX);
  assign jr     = valid & (op == OP_JR);
  assign branch = valid & ((op == OP_BNE) | (op == OP_BLT));
endmodule

// File: rtl/fd_queue_stage.sv
// Fetch/decode stage: DEPTH-entry circular instruction queue with pre-decoded head and flush.
module fd_queue_stage
  import fd_pkg::*;
#(
  parameter int PC_W    = 32,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = $clog2(DEPTH) + 1
) (
  input  logic                rise,
  input  logic                reset,
  fd_queue_stage_if.slave     fetch,
  input  logic                flush,
  input  logic                dec_ready,
  output logic                fd_valid,
  output logic [PC_W-1:0]     pc_fd,
  output logic [INSTR_W-1:0]  instr_fd,
  output logic [4:0]          rd_fd,
  output logic [4:0]          rs_fd,
  output logic [4:0]          rt_fd,
  output logic                rtype_fd,
  output logic                addi_fd,
  output logic                bex_fd,
  output logic                jr_fd,
  output logic                branch_fd,
  output logic [CNT_W-1:0]    occupancy
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               push, pop;

  // Ready comes only from registered count so fetch never sees a path from dec_ready.
  assign fetch.fetch_ready = (count != CNT_W'(DEPTH));
  assign fd_valid          = (count != '0);
  assign push              = fetch.fetch_valid & fetch.fetch_ready;
  assign pop               = fd_valid & dec_ready;
  assign occupancy         = count;

  assign pc_fd    = fd_valid ? pc_mem[rd_ptr]    : '0;
  assign instr_fd = fd_valid ? instr_mem[rd_ptr] : '0;

  // DEPTH is a power of two, so pointer increments wrap without compare logic.
  always_ff @(posedge rise) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_ptr]    <= fetch.pc_in;
        instr_mem[wr_ptr] <= fetch.instr_in;
        wr_ptr            <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  fd_decode u_decode (
    .instr_hi (instr_fd[OP_LSB+4:RT_LSB]),
    .valid    (fd_valid),
    .rd       (rd_fd),
    .rs       (rs_fd),
    .rt       (rt_fd),
    .rtype    (rtype_fd),
    .addi     (addi_fd),
    .bex      (bex_fd),
    .jr       (jr_fd),
    .branch   (branch_fd)
  );
endmodule

// File: tb/tb_fd_queue_stage.sv
// Directed plus random checks of fd_queue_stage against a queue-based reference model.
module tb_fd_queue_stage;
  localparam int PC_W    = 32;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = $clog2(DEPTH) + 1;

  logic               rise = 1'b0;
  logic               reset, flush, dec_ready;
  logic               fd_valid;
  logic [PC_W-1:0]    pc_fd;
  logic [INSTR_W-1:0] instr_fd;
  logic [4:0]         rd_fd, rs_fd, rt_fd;
  logic               rtype_fd, addi_fd, bex_fd, jr_fd, branch_fd;
  logic [CNT_W-1:0]   occupancy;

  int n_assert = 0;
  int n_fail   = 0;

  logic [PC_W-1:0]    pcq [$];
  logic [INSTR_W-1:0] iq  [$];

  fd_queue_stage_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) fif ();

  fd_queue_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
    .rise      (rise),
    .reset     (reset),
    .fetch     (fif),
    .flush     (flush),
    .dec_ready (dec_ready),
    .fd_valid  (fd_valid),
    .pc_fd     (pc_fd),
    .instr_fd  (instr_fd),
    .rd_fd     (rd_fd),
    .rs_fd     (rs_fd),
    .rt_fd     (rt_fd),
    .rtype_fd  (rtype_fd),
    .addi_fd   (addi_fd),
    .bex_fd    (bex_fd),
    .jr_fd     (jr_fd),
    .branch_fd (branch_fd),
    .occupancy (occupancy)
  );

  always #5 rise = ~rise;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs come straight from the model queue head and the opcode table.
  task automatic check_all();
    logic               ev;
    logic [PC_W-1:0]    hp;
    logic [INSTR_W-1:0] hi;
    logic [4:0]         op;
    ev = (pcq.size() != 0);
    hp = ev ? pcq[0] : '0;
    hi = ev ? iq[0]  : '0;
    op = hi[31:27];
    chk("fd_valid",    64'(fd_valid),    64'(ev));
    chk("fetch_ready", 64'(fif.fetch_ready), 64'(pcq.size() != DEPTH));
    chk("occupancy",   64'(occupancy),   64'(pcq.size()));
    chk("occ_bound",   64'(occupancy <= CNT_W'(DEPTH)), 64'd1);
    chk("pc_fd",       64'(pc_fd),       64'(hp));
    chk("instr_fd",    64'(instr_fd),    64'(hi));
    chk("rd_fd",       64'(rd_fd),       64'(hi[26:22]));
    chk("rs_fd",       64'(rs_fd),       64'(hi[21:17]));
    chk("rt_fd",       64'(rt_fd),       64'(hi[16:12]));
    chk("rtype_fd",    64'(rtype_fd),    64'(ev && op == 5'b00000));
    chk("addi_fd",     64'(addi_fd),     64'(ev && op == 5'b00101));
    chk("bex_fd",      64'(bex_fd),      64'(ev && op == 5'b10110));
    chk("jr_fd",       64'(jr_fd),       64'(ev && op == 5'b00100));
    chk("branch_fd",   64'(branch_fd),   64'(ev && (op == 5'b00010 || op == 5'b00110)));
  endtask

  // One clock: drive at negedge, optional sub-cycle reset glitch, update model at posedge, check.
  task automatic step(input logic fv, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                      input logic dr, input logic fl, input logic rs, input logic glitch = 1'b0);
    logic push, pop;
    @(negedge rise);
    fif.fetch_valid = fv;
    fif.pc_in       = pc;
    fif.instr_in    = ins;
    dec_ready       = dr;
    flush           = fl;
    reset           = rs;
    if (glitch) begin
      #1 reset = 1'b1;
      #1 reset = 1'b0;
    end
    push = fv && (pcq.size() != DEPTH);
    pop  = (pcq.size() != 0) && dr;
    @(posedge rise);
    if (rs || fl) begin
      pcq.delete();
      iq.delete();
    end else begin
      if (pop) begin
        void'(pcq.pop_front());
        void'(iq.pop_front());
      end
      if (push) begin
        pcq.push_back(pc);
        iq.push_back(ins);
      end
    end
    #1 check_all();
  endtask

  initial begin
    logic [4:0]         ops [7];
    logic [INSTR_W-1:0] ins;
    ops = '{5'b00000, 5'b00010, 5'b00100, 5'b00101, 5'b00110, 5'b10110, 5'b11111};
    fif.fetch_valid = 1'b0;
    fif.pc_in       = '0;
    fif.instr_in    = '0;
    dec_ready       = 1'b0;
    flush           = 1'b0;
    reset           = 1'b1;

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_ready", 64'(fif.fetch_ready), 64'd1);

    // Single addi push
    step(1, 32'h10, 32'h2800_0000, 0, 0, 0);
    chk("addi_push", 64'(addi_fd), 64'd1);
    chk("addi_pc",   64'(pc_fd),   64'h10);

    // Fill, overflow attempt, ordered drain
    step(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < DEPTH; i++) step(1, PC_W'(i), INSTR_W'(32'h100 + i), 0, 0, 0);
    chk("full_ready", 64'(fif.fetch_ready), 64'd0);
    chk("full_occ",   64'(occupancy), 64'(DEPTH));
    step(1, 32'h4, 32'hdead, 0, 0, 0);
    chk("overflow_occ", 64'(occupancy), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 64'(pc_fd), 64'(i));
      step(0, 0, 0, 1, 0, 0);
    end

    // Continuous push/pop across pointer wrap: head lags input by one cycle
    step(1, 32'h200, 32'h0, 1, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, PC_W'(32'h200 + i), INSTR_W'(i), 1, 0, 0);
      chk("stream_pc", 64'(pc_fd), 64'(32'h200 + i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    step(0, 0, 0, 1, 0, 0);

    // Flush with three entries while a push is offered
    for (int i = 0; i < 3; i++) step(1, PC_W'(32'h300 + i), {5'b00010, 27'h0}, 0, 0, 0);
    step(1, 32'h3ff, {5'b00110, 27'h0}, 0, 1, 0);
    chk("flush_occ",    64'(occupancy), 64'd0);
    chk("flush_branch", 64'(branch_fd), 64'd0);
    step(0, 0, 0, 0, 1, 0);

    // Decode sweep with rd=5 rs=7 rt=9
    for (int k = 0; k < 7; k++) begin
      ins = {ops[k], 5'd5, 5'd7, 5'd9, 12'h0};
      step(1, PC_W'(32'h400 + k), ins, 0, 0, 0);
      chk("sweep_rd", 64'(rd_fd), 64'd5);
      step(0, 0, 0, 1, 0, 0);
    end

    // Reset while full and popping
    for (int i = 0; i < DEPTH; i++) step(1, PC_W'(32'h500 + i), {5'b10110, 27'h1}, 0, 0, 0);
    step(1, 32'h5ff, 32'h0, 1, 0, 1);
    chk("rst_full_valid", 64'(fd_valid), 64'd0);
    chk("rst_full_ready", 64'(fif.fetch_ready), 64'd1);

    // Sub-cycle reset glitch must be ignored
    step(1, 32'h600, {5'b00100, 27'h0}, 0, 0, 0);
    step(1, 32'h601, 32'h0, 0, 0, 0, 1'b1);
    chk("glitch_occ", 64'(occupancy), 64'd2);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      ins = {ops[$urandom_range(0, 6)], 27'($urandom)};
      step(($urandom % 4) != 0, PC_W'($urandom), ins, $urandom % 2 == 1,
           ($urandom % 25) == 0, ($urandom % 60) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
